// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the minimal 6502 computer.
package cpu6502_pkg;

  typedef enum logic [3:0] {
    RESET, VECLO, VECHI, FETCH, OPER1, OPER2, EXEC, BRTAKEN, BRPAGE
  } state_t;

  // Memory map
  localparam logic [15:0] ROM_BASE  = 16'hF000;
  localparam logic [15:0] RAM_LIMIT = 16'h01FF;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;

  // Status register bit positions
  localparam int FC = 0;
  localparam int FZ = 1;
  localparam int FI = 2;
  localparam int FD = 3;
  localparam int FB = 4;
  localparam int FV = 6;
  localparam int FN = 7;

  localparam logic [7:0] P_RESET = 8'h24;

  // Opcodes
  localparam logic [7:0] OP_LDA_IMM = 8'hA9, OP_LDA_ZP = 8'hA5;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2, OP_LDX_ZP = 8'hA6;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0, OP_LDY_ZP = 8'hA4;
  localparam logic [7:0] OP_STA_ZP  = 8'h85, OP_STX_ZP = 8'h86, OP_STY_ZP = 8'h84;
  localparam logic [7:0] OP_ADC_IMM = 8'h69, OP_SBC_IMM = 8'hE9;
  localparam logic [7:0] OP_AND_IMM = 8'h29, OP_ORA_IMM = 8'h09, OP_EOR_IMM = 8'h49;
  localparam logic [7:0] OP_CMP_IMM = 8'hC9, OP_CPX_IMM = 8'hE0, OP_CPY_IMM = 8'hC0;
  localparam logic [7:0] OP_INX = 8'hE8, OP_INY = 8'hC8, OP_DEX = 8'hCA, OP_DEY = 8'h88;
  localparam logic [7:0] OP_TAX = 8'hAA, OP_TXA = 8'h8A, OP_TAY = 8'hA8, OP_TYA = 8'h98;
  localparam logic [7:0] OP_CLC = 8'h18, OP_SEC = 8'h38, OP_CLV = 8'hB8, OP_NOP = 8'hEA;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;

  // All eight conditional branches share the xxy10000 pattern:
  // xx selects the flag (N, V, C, Z), y is the value that takes the branch.
  function automatic logic is_branch(input logic [7:0] op);
    return op[4:0] == 5'b10000;
  endfunction

  function automatic logic branch_taken(input logic [7:0] op, input logic [7:0] p);
    logic f;
    case (op[7:6])
      2'b00:   f = p[FN];
      2'b01:   f = p[FV];
      2'b10:   f = p[FC];
      default: f = p[FZ];
    endcase
    return f == op[5];
  endfunction

endpackage

// File: rtl/cpu6502_if.sv
// CPU <-> memory bus: combinational read data, write strobe sampled on ph1.
interface cpu6502_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/cpu6502_memory.sv
// ROM at the top of the map, RAM at the bottom, everything else reads 0.
module memory import cpu6502_pkg::*; #(
  parameter int ROM_WORDS = 4096,
  parameter int RAM_WORDS = 512
) (
  input logic       clk,
  cpu6502_if.slave  bus
);
  localparam int ROM_AW = $clog2(ROM_WORDS);
  localparam int RAM_AW = $clog2(RAM_WORDS);

  logic [7:0] ROM [ROM_WORDS];
  logic [7:0] RAM [RAM_WORDS];

  logic rom_sel, ram_sel;
  assign rom_sel = bus.addr >= ROM_BASE;
  assign ram_sel = bus.addr <= RAM_LIMIT;

  // Combinational read decode
  always_comb begin
    bus.rdata = 8'h00;
    if (rom_sel)      bus.rdata = ROM[bus.addr[ROM_AW-1:0]];
    else if (ram_sel) bus.rdata = RAM[bus.addr[RAM_AW-1:0]];
  end

  // Only RAM is writable; ROM and holes silently drop the write
  always_ff @(posedge clk) begin
    if (bus.we && ram_sel) RAM[bus.addr[RAM_AW-1:0]] <= bus.wdata;
  end
endmodule

// File: rtl/top.sv
// Minimal 6502-compatible computer: multi-cycle core plus ROM/RAM block.
module top import cpu6502_pkg::*; #(
  parameter int          ROM_WORDS = 4096,
  parameter int          RAM_WORDS = 512,
  parameter logic [15:0] RESET_VEC = VEC_RESET
) (
  input logic ph1,
  input logic ph2,
  input logic reset
);
  cpu6502_if bus ();

  memory #(.ROM_WORDS(ROM_WORDS), .RAM_WORDS(RAM_WORDS)) mem (.clk(ph1), .bus(bus));

  state_t      state, nxt;
  logic [7:0]  a, x, y, s, p, ir, opl, oph;
  logic [7:0]  a_n, x_n, y_n, p_n, ir_n, opl_n, oph_n;
  logic [15:0] pc, pc_n, target;

  // ph2 is a legacy pin and the stack pointer has no users yet
  logic unused_ok;
  assign unused_ok = ^{ph2, s};

  logic is_imm, is_ld_zp, is_st_zp;
  assign is_imm   = ir inside {OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_ADC_IMM, OP_SBC_IMM,
                               OP_AND_IMM, OP_ORA_IMM, OP_EOR_IMM, OP_CMP_IMM, OP_CPX_IMM,
                               OP_CPY_IMM};
  assign is_ld_zp = ir inside {OP_LDA_ZP, OP_LDX_ZP, OP_LDY_ZP};
  assign is_st_zp = ir inside {OP_STA_ZP, OP_STX_ZP, OP_STY_ZP};

  // Execute unit: the operand is always whatever is on the read bus in
  // the committing cycle (immediate byte in OPER1, zp byte in EXEC).
  logic [7:0] ex_a, ex_x, ex_y, ex_p, res, addend, cmp_reg;
  logic [8:0] sum;
  logic       nz;
  always_comb begin
    ex_a = a; ex_x = x; ex_y = y; ex_p = p;
    res = 8'h00; nz = 1'b0; sum = 9'h000;
    addend  = (ir == OP_SBC_IMM) ? ~bus.rdata : bus.rdata;
    cmp_reg = (ir == OP_CPX_IMM) ? x : (ir == OP_CPY_IMM) ? y : a;
    case (ir)
      OP_LDA_IMM, OP_LDA_ZP: begin ex_a = bus.rdata; res = bus.rdata; nz = 1'b1; end
      OP_LDX_IMM, OP_LDX_ZP: begin ex_x = bus.rdata; res = bus.rdata; nz = 1'b1; end
      OP_LDY_IMM, OP_LDY_ZP: begin ex_y = bus.rdata; res = bus.rdata; nz = 1'b1; end
      OP_ADC_IMM, OP_SBC_IMM: begin
        sum      = {1'b0, a} + {1'b0, addend} + {8'h00, p[FC]};
        ex_a     = sum[7:0];
        res      = sum[7:0];
        nz       = 1'b1;
        ex_p[FC] = sum[8];
        ex_p[FV] = (a[7] == addend[7]) && (sum[7] != a[7]);
      end
      OP_AND_IMM: begin ex_a = a & bus.rdata; res = ex_a; nz = 1'b1; end
      OP_ORA_IMM: begin ex_a = a | bus.rdata; res = ex_a; nz = 1'b1; end
      OP_EOR_IMM: begin ex_a = a ^ bus.rdata; res = ex_a; nz = 1'b1; end
      OP_CMP_IMM, OP_CPX_IMM, OP_CPY_IMM: begin
        res      = cmp_reg - bus.rdata;
        nz       = 1'b1;
        ex_p[FC] = cmp_reg >= bus.rdata;
      end
      OP_INX: begin ex_x = x + 8'd1; res = ex_x; nz = 1'b1; end
      OP_INY: begin ex_y = y + 8'd1; res = ex_y; nz = 1'b1; end
      OP_DEX: begin ex_x = x - 8'd1; res = ex_x; nz = 1'b1; end
      OP_DEY: begin ex_y = y - 8'd1; res = ex_y; nz = 1'b1; end
      OP_TAX: begin ex_x = a; res = a; nz = 1'b1; end
      OP_TXA: begin ex_a = x; res = x; nz = 1'b1; end
      OP_TAY: begin ex_y = a; res = a; nz = 1'b1; end
      OP_TYA: begin ex_a = y; res = y; nz = 1'b1; end
      OP_CLC: ex_p[FC] = 1'b0;
      OP_SEC: ex_p[FC] = 1'b1;
      OP_CLV: ex_p[FV] = 1'b0;
      default: ;
    endcase
    if (nz) begin
      ex_p[FN] = res[7];
      ex_p[FZ] = (res == 8'h00);
    end
  end

  // Next-state, bus drive and register updates
  always_comb begin
    nxt = state;
    a_n = a; x_n = x; y_n = y; p_n = p; pc_n = pc;
    ir_n = ir; opl_n = opl; oph_n = oph;
    bus.addr  = pc;
    bus.wdata = 8'h00;
    bus.we    = 1'b0;
    target    = pc + {{8{opl[7]}}, opl};
    case (state)
      RESET: nxt = VECLO;
      VECLO: begin bus.addr = RESET_VEC; opl_n = bus.rdata; nxt = VECHI; end
      VECHI: begin bus.addr = RESET_VEC + 16'd1; pc_n = {bus.rdata, opl}; nxt = FETCH; end
      FETCH: begin ir_n = bus.rdata; pc_n = pc + 16'd1; nxt = OPER1; end
      OPER1: begin
        if (is_branch(ir)) begin
          pc_n  = pc + 16'd1;
          opl_n = bus.rdata;
          nxt   = branch_taken(ir, p) ? BRTAKEN : FETCH;
        end else if (ir == OP_JMP_ABS) begin
          pc_n = pc + 16'd1; opl_n = bus.rdata; nxt = OPER2;
        end else if (is_ld_zp || is_st_zp) begin
          pc_n = pc + 16'd1; opl_n = bus.rdata; nxt = EXEC;
        end else begin
          // implied, immediate and unknown opcodes all finish here
          a_n = ex_a; x_n = ex_x; y_n = ex_y; p_n = ex_p;
          if (is_imm) pc_n = pc + 16'd1;
          nxt = FETCH;
        end
      end
      OPER2: begin pc_n = {bus.rdata, opl}; nxt = FETCH; end
      EXEC: begin
        bus.addr = {8'h00, opl};
        if (is_st_zp) begin
          // a reset landing on this cycle must not leave a partial store
          bus.we    = ~reset;
          bus.wdata = (ir == OP_STA_ZP) ? a : (ir == OP_STX_ZP) ? x : y;
        end else begin
          a_n = ex_a; x_n = ex_x; y_n = ex_y; p_n = ex_p;
        end
        nxt = FETCH;
      end
      BRTAKEN: begin
        if (target[15:8] == pc[15:8]) begin
          pc_n = target; nxt = FETCH;
        end else begin
          {oph_n, opl_n} = target; nxt = BRPAGE;
        end
      end
      BRPAGE: begin pc_n = {oph, opl}; nxt = FETCH; end
      default: nxt = RESET;
    endcase
  end

  // FSM state register
  always_ff @(posedge ph1) begin
    if (reset) state <= RESET;
    else       state <= nxt;
  end

  // Architectural and scratch registers
  always_ff @(posedge ph1) begin
    if (reset) begin
      a <= 8'h00; x <= 8'h00; y <= 8'h00; s <= 8'hFF; p <= P_RESET;
      pc <= 16'h0000; ir <= 8'h00; opl <= 8'h00; oph <= 8'h00;
    end else begin
      a <= a_n; x <= x_n; y <= y_n; p <= p_n;
      pc <= pc_n; ir <= ir_n; opl <= opl_n; oph <= oph_n;
    end
  end
endmodule

// File: tb/tb_top.sv
// Directed bench for the 6502 computer: small ROM programs, results read
// back from zero-page RAM and core registers, plus a standalone memory check.
module tb_top;
  import cpu6502_pkg::*;

  logic ph1 = 1'b0;
  logic ph2;
  logic reset = 1'b1;
  int   nchk = 0;
  int   nfail = 0;
  int   cyc = 0;
  logic [15:0] pa;

  always #5 ph1 = ~ph1;
  assign ph2 = ~ph1;
  always @(posedge ph1) cyc <= cyc + 1;

  top dut (.ph1(ph1), .ph2(ph2), .reset(reset));

  cpu6502_if mbus ();
  memory mtest (.clk(ph1), .bus(mbus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic emit(input logic [7:0] b);
    dut.mem.ROM[pa[11:0]] = b;
    pa = pa + 16'd1;
  endtask

  task automatic e1(input logic [7:0] b0); emit(b0); endtask
  task automatic e2(input logic [7:0] b0, input logic [7:0] b1); emit(b0); emit(b1); endtask
  task automatic e3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    emit(b0); emit(b1); emit(b2);
  endtask

  task automatic set_vec(input logic [15:0] v);
    dut.mem.ROM[12'hFFC] = v[7:0];
    dut.mem.ROM[12'hFFD] = v[15:8];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (5) @(posedge ph1);
    #1 reset = 1'b0;
  endtask

  task automatic wait_fetch(input logic [15:0] target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge ph1);
      if (dut.state == FETCH && dut.pc == target) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int t0, t1, t2, t3;
    mbus.addr = 16'h0000; mbus.wdata = 8'h00; mbus.we = 1'b0;

    // ---- Program A: branch suite, taken and not-taken for C, V, N ----
    set_vec(16'hF000);
    pa = 16'hF000;
    e2(8'hA9, 8'h7F); e1(8'h18); e2(8'h69, 8'h01);   // A=80 V=1 N=1 C=0
    e2(8'h50, 8'h02); e2(8'hA0, 8'h08);             // BVC nt, LDY #08
    e2(8'h70, 8'h02); e2(8'hA0, 8'h80);             // BVS t, skip
    e1(8'h98); e1(8'hB8);                           // TYA, CLV
    e2(8'h70, 8'h02); e2(8'h09, 8'h04);             // BVS nt, ORA #04
    e2(8'h50, 8'h02); e2(8'h09, 8'h80);             // BVC t, skip
    e1(8'h18); e2(8'hB0, 8'h02); e2(8'h09, 8'h01);  // CLC, BCS nt, ORA #01
    e2(8'h90, 8'h02); e2(8'h09, 8'h80);             // BCC t, skip
    e1(8'h38); e2(8'h90, 8'h02); e2(8'h09, 8'h02);  // SEC, BCC nt, ORA #02
    e2(8'hB0, 8'h02); e2(8'h09, 8'h80);             // BCS t, skip
    e2(8'hA2, 8'hFF); e2(8'h10, 8'h02); e2(8'h09, 8'h10); // N=1, BPL nt, ORA #10
    e2(8'h30, 8'h02); e1(8'hAA);                    // BMI nt, TAX
    e2(8'h10, 8'h02); e2(8'hA9, 8'hFF);             // BPL t, skip
    e2(8'hA0, 8'h80); e2(8'h30, 8'h02); e2(8'hA9, 8'hFF); // N=1, BMI t, skip
    e2(8'h85, 8'h80); e2(8'h86, 8'h81); e3(8'h4C, 8'h40, 8'hF0);

    do_reset();
    check("reset_a", dut.a, 8'h00);
    check("reset_x", dut.x, 8'h00);
    check("reset_y", dut.y, 8'h00);
    check("reset_s", dut.s, 8'hFF);
    check("reset_p", dut.p, 8'h24);
    check("reset_state", dut.state, RESET);
    @(posedge ph1); #1;
    check("vec_lo_addr", dut.bus.addr, 16'hFFFC);
    @(posedge ph1); #1;
    check("vec_hi_addr", dut.bus.addr, 16'hFFFD);
    @(posedge ph1); #1;
    check("first_fetch_addr", dut.bus.addr, 16'hF000);
    check("first_fetch_state", dut.state, FETCH);

    ok = 1'b0;
    for (int i = 0; i < 117; i++) begin
      @(negedge ph1);
      if (dut.mem.RAM[9'h080] === 8'h1F) begin ok = 1'b1; break; end
    end
    check("branch_in_time", ok, 1'b1);
    check("branch_ram80", dut.mem.RAM[9'h080], 8'h1F);
    wait_fetch(16'hF040, 20, ok);
    check("branch_ram81", dut.mem.RAM[9'h081], 8'h1F);
    check("branch_y", dut.y, 8'h80);

    // ---- Program B: ADC overflow flags ----
    set_vec(16'hF000);
    pa = 16'hF000;
    e2(8'hA0, 8'h00); e2(8'hA9, 8'h7F); e1(8'h18); e2(8'h69, 8'h01);
    e2(8'h85, 8'h80);
    e2(8'h70, 8'h02); e2(8'hA0, 8'hFF);             // BVS t, skip
    e2(8'h30, 8'h02); e2(8'hA0, 8'hFF);             // BMI t, skip
    e3(8'h4C, 8'h11, 8'hF0);
    do_reset();
    wait_fetch(16'hF011, 60, ok);
    check("adc_reached", ok, 1'b1);
    check("adc_ram80", dut.mem.RAM[9'h080], 8'h80);
    check("adc_v", dut.p[FV], 1'b1);
    check("adc_n", dut.p[FN], 1'b1);
    check("adc_c", dut.p[FC], 1'b0);
    check("adc_z", dut.p[FZ], 1'b0);
    check("adc_probe_y", dut.y, 8'h00);

    // ---- Program C: CPX and BEQ ----
    set_vec(16'hF000);
    pa = 16'hF000;
    e2(8'hA9, 8'hAA); e2(8'h85, 8'h81);             // RAM[81] = AA
    e2(8'hA2, 8'h05); e2(8'hE0, 8'h05);             // LDX #5, CPX #5
    e2(8'hF0, 8'h02); e2(8'h86, 8'h81);             // BEQ t, skip STX
    e2(8'hE0, 8'h06); e3(8'h4C, 8'h0E, 8'hF0);      // CPX #6, loop
    do_reset();
    wait_fetch(16'hF00C, 60, ok);
    check("cpx_eq_reached", ok, 1'b1);
    check("cpx_eq_ram81", dut.mem.RAM[9'h081], 8'hAA);
    check("cpx_eq_c", dut.p[FC], 1'b1);
    check("cpx_eq_z", dut.p[FZ], 1'b1);
    wait_fetch(16'hF00E, 10, ok);
    check("cpx_lt_reached", ok, 1'b1);
    check("cpx_lt_c", dut.p[FC], 1'b0);
    check("cpx_lt_z", dut.p[FZ], 1'b0);
    check("cpx_lt_n", dut.p[FN], 1'b1);

    // ---- Program D: branch cycle counts incl. page cross ----
    set_vec(16'hF0F8);
    pa = 16'hF0F8;
    e1(8'h38); e2(8'h90, 8'h02);                    // SEC, BCC nt
    e2(8'hB0, 8'h00);                               // BCS +0 t, same page
    e2(8'hB0, 8'h10);                               // BCS +10 t, crosses
    e2(8'hA9, 8'hFF);                               // must not run
    pa = 16'hF10F;
    e3(8'h4C, 8'h0F, 8'hF1);
    do_reset();
    wait_fetch(16'hF0F9, 20, ok);
    check("pg_reach0", ok, 1'b1);
    t0 = cyc;
    wait_fetch(16'hF0FB, 10, ok);
    check("pg_reach1", ok, 1'b1);
    t1 = cyc;
    wait_fetch(16'hF0FD, 10, ok);
    check("pg_reach2", ok, 1'b1);
    t2 = cyc;
    wait_fetch(16'hF10F, 10, ok);
    check("pg_reach3", ok, 1'b1);
    t3 = cyc;
    check("br_nt_cycles", t1 - t0, 2);
    check("br_t_cycles", t2 - t1, 3);
    check("br_pgx_cycles", t3 - t2, 4);
    check("br_pgx_no_fallthru", dut.a, 8'h00);

    // ---- Program E: reset during a store's final cycle ----
    set_vec(16'hF000);
    pa = 16'hF000;
    e2(8'hA9, 8'h11); e2(8'h85, 8'h82);
    e2(8'hA9, 8'h22); e2(8'h85, 8'h82);
    e3(8'h4C, 8'h08, 8'hF0);
    do_reset();
    wait_fetch(16'hF006, 40, ok);
    check("st_reach", ok, 1'b1);
    check("st_first_write", dut.mem.RAM[9'h082], 8'h11);
    @(negedge ph1);
    @(negedge ph1);
    check("st_exec_state", dut.state, EXEC);
    check("st_we_before", dut.bus.we, 1'b1);
    reset = 1'b1;
    #1;
    check("st_we_gated", dut.bus.we, 1'b0);
    @(negedge ph1);
    check("st_abort_state", dut.state, RESET);
    check("st_abort_ram82", dut.mem.RAM[9'h082], 8'h11);
    check("st_abort_a", dut.a, 8'h00);

    // ---- Standalone memory decode ----
    mtest.ROM[0]       = 8'hEA;
    mtest.ROM[12'hFFF] = 8'hC3;
    @(negedge ph1);
    mbus.addr = 16'hF000; mbus.wdata = 8'h55; mbus.we = 1'b1;
    @(negedge ph1); mbus.we = 1'b0; #1;
    check("mem_rom_kept", mtest.ROM[0], 8'hEA);
    check("mem_rom_read", mbus.rdata, 8'hEA);
    mbus.addr = 16'h0000; mbus.wdata = 8'h33; mbus.we = 1'b1;
    @(negedge ph1); mbus.we = 1'b0; #1;
    check("mem_ram_write", mbus.rdata, 8'h33);
    mbus.addr = 16'h8000; mbus.wdata = 8'h77; mbus.we = 1'b1;
    @(negedge ph1); mbus.we = 1'b0; #1;
    check("mem_unmapped_read", mbus.rdata, 8'h00);
    mbus.addr = 16'h0200; mbus.wdata = 8'h44; mbus.we = 1'b1;
    @(negedge ph1); mbus.we = 1'b0; mbus.addr = 16'h0000; #1;
    check("mem_no_alias", mbus.rdata, 8'h33);
    mbus.addr = 16'h01FF; mbus.wdata = 8'h5A; mbus.we = 1'b1;
    @(negedge ph1); mbus.we = 1'b0; #1;
    check("mem_ram_top", mbus.rdata, 8'h5A);
    mbus.addr = 16'hFFFF; #1;
    check("mem_rom_top", mbus.rdata, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/top.md
Name: top

Overview:
- Minimal 6502-compatible computer: a small multi-cycle CPU core plus a memory sub-block (instance name `mem`) holding ROM and RAM.
- The CPU starts from the reset vector and executes ROM code.
- Results land in zero-page RAM; benches read them hierarchically as `top.mem.RAM[n]`.
- Benches preload code and vectors through `top.mem.ROM[n]`.

Parameters:
- ROM_WORDS, 4096, ROM size in bytes; mapped at 0xF000–0xFFFF; array index = addr[11:0].
- RAM_WORDS, 512, RAM size in bytes; mapped at 0x0000–0x01FF (zero page + stack); array index = addr[8:0].
- RESET_VEC, 16'hFFFC, address of the low byte of the reset vector (high byte at +1).

Ports:
- ph1  input  1  Single system clock; all state updates on the rising edge.
- ph2  input  1  Phase-2 clock from the two-phase generator; kept for interface compatibility, no functional effect.
- reset  input  1  Synchronous, active-high reset, sampled on the ph1 rising edge.

Behaviour:
- Clocking: one clock (ph1 rising edge). Reset is synchronous, active-high. No internal logic uses ph2.
- Reset state:
  - A = X = Y = 0, S = 0xFF, P = 0x24 (I = 1, bit 5 = 1).
  - FSM held in RESET; no memory writes; RAM/ROM contents untouched.
- After reset deasserts:
  - Cycle 1 reads vector low byte at 0xFFFC; cycle 2 reads high byte at 0xFFFD.
  - PC = {hi, lo}; the opcode fetch follows.
- Reset asserted mid-instruction aborts it immediately; any in-flight store is suppressed.
- Memory map (`mem` sub-block, arrays named exactly `ROM` and `RAM`, 8-bit entries):
  - Reads are combinational from the address bus.
  - RAM writes occur on the ph1 rising edge when we = 1.
  - Writes to ROM or unmapped space are ignored.
  - Unmapped reads return 0x00.
- FSM states: RESET, VECLO, VECHI, FETCH, OPER1, OPER2, EXEC, BRTAKEN, BRPAGE.
  - Cycle counts never exceed NMOS 6502 counts:
    - implied / immediate: 2
    - zp load/store: 3
    - JMP abs: 3
    - branch not taken: 2; taken: 3; taken with page cross: 4
- Supported opcodes:
  - LDA/LDX/LDY #imm and zp
  - STA/STX/STY zp
  - ADC/SBC/AND/ORA/EOR/CMP #imm, CPX/CPY #imm
  - INX/INY/DEX/DEY, TAX/TXA/TAY/TYA
  - CLC/SEC/CLV/NOP
  - BPL/BMI/BVC/BVS/BCC/BCS/BNE/BEQ
  - JMP abs
- Any other opcode executes as a 2-cycle, 1-byte NOP.
- Flags:
  - N = result[7]; Z = (result == 0).
  - ADC: C = carry out; V = signed overflow.
  - SBC = ADC of ~operand (binary only; D flag ignored).
  - CMP/CPX/CPY: C = (reg >= operand), no register write.
  - Loads, transfers, INC/DEC and logic ops update N and Z only.
- Branches: offset is signed 8-bit, added to the PC of the next instruction; wrap-around is 16-bit modulo.
- PC increments modulo 2^16.

Decomposition:
- Shared package `cpu6502_pkg`:
  - FSM state enum.
  - Opcode constants.
  - Flag bit indices (C=0, Z=1, I=2, D=3, B=4, V=6, N=7).
  - Memory-map constants: ROM base 0xF000, RAM limit 0x01FF, reset vector.
- One natural sub-module: `memory` (instance `mem`) holding the ROM/RAM arrays and address decode.
- CPU datapath and FSM stay in `top`.

Test Plan:
- Reset vector: ROM[0xFFC] = 0x00, ROM[0xFFD] = 0xF0, reset high 5 cycles -> first opcode fetch from 0xF000 on cycle 3 after deassert.
- Branch suite:
  - Program sets RAM[0x80] bits via BCC/BCS/BVC/BVS/BPL/BMI, each taken and not taken.
  - Required: RAM[0x80] == 0x1F within 120 cycles of reset release.
- ADC flags: LDA #$7F, CLC, ADC #$01, STA $80, then PHP-free flag probe via BVS/BMI -> RAM[0x80] == 0x80, V = 1, N = 1, C = 0, Z = 0.
- Compare/BEQ:
  - LDX #$05; CPX #$05; BEQ skips a STX $81 -> RAM[0x81] unchanged, C = 1, Z = 1.
  - CPX #$06 -> C = 0, Z = 0, N = 1.
- Branch page cross: branch at 0xF0FD with offset +0x10 taken -> target 0xF10F, taken branch costs exactly 4 cycles.
- Store isolation:
  - STA to 0xF000 (via JMP setup) leaves ROM unchanged.
  - Reset asserted during an STA's final cycle -> target RAM byte unchanged.
